branch_predictor: RTL and testbench

Dynamic branch predictor for the pipelined RV32I core. It is the fetch-side counterpart of EX-stage branch resolution.
- IF stage looks up the fetch PC and gets a taken/not-taken prediction plus a target, from a direct-mapped BHT of 2-bit saturating counters and a tagged BTB.
- EX stage returns the resolved outcome. The block then trains its tables, flags mispredicts, supplies the redirect PC, and keeps performance counters.

---
 rtl/branch_predictor.sv | 107 ++++++++++
 tb/tb_branch_predictor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor: direct-mapped BHT of 2-bit saturating
// counters plus a tagged BTB, trained by EX-stage branch resolution.
module branch_predictor #(
    parameter int         ENTRIES   = 16,
    parameter int         IDX_W     = 4,
    parameter logic [1:0] CNT_RESET = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int TAG_W = 32 - IDX_W - 2;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_cnt    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [31:0]        r_branch_count;
    logic [31:0]        r_mispredict_count;

    logic [IDX_W-1:0]   w_if_idx;
    logic [TAG_W-1:0]   w_if_tag;
    logic               w_if_hit;
    logic [IDX_W-1:0]   w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_upd_hit;
    logic [1:0]         w_cnt_next;
    logic               w_mispredict;

    // Lookup: reads pre-update table contents, no bypass from a same-cycle update.
    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_if_tag    = if_pc[31:IDX_W+2];
    assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
    assign pred_target = pred_taken ? r_target[w_if_idx] : if_pc + 32'd4;

    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[31:IDX_W+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    always_comb begin
        w_cnt_next = upd_taken ? 2'b10 : 2'b01;
        if (w_upd_hit) begin
            w_cnt_next = upd_taken ? sat_inc(r_cnt[w_upd_idx]) : sat_dec(r_cnt[w_upd_idx]);
        end
    end

    // A taken branch with the right direction but a stale target still needs a flush.
    assign w_mispredict = upd_valid &&
                          ((upd_taken != upd_pred_taken) ||
                           (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    assign mispredict       = w_mispredict;
    assign redirect_pc      = upd_taken ? upd_target : upd_pc + 32'd4;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid            <= '0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= CNT_RESET;
            end
        end else if (upd_valid) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_cnt[w_upd_idx]   <= w_cnt_next;
            r_branch_count     <= r_branch_count + 32'd1;
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    // Tags and targets are qualified by r_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            r_tag[w_upd_idx] <= w_upd_tag;
            if (upd_taken) begin
                r_target[w_upd_idx] <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_chk = 0;
    int n_err = 0;

    branch_predictor #(.ENTRIES(16), .IDX_W(4), .CNT_RESET(2'b01)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic etk, input logic [31:0] etg);
        if_pc = pc;
        #1;
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, etk});
        chk("pred_target", pred_target, etg);
    endtask

    task automatic counts(input logic [31:0] ebc, input logic [31:0] emc);
        chk("branch_count", branch_count, ebc);
        chk("mispredict_count", mispredict_count, emc);
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                           input logic ptk, input logic [31:0] ptg);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tg;
        upd_pred_taken  = ptk;
        upd_pred_target = ptg;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic ptk, input logic [31:0] ptg,
                       input logic emis, input logic [31:0] ered);
        set_upd(pc, tk, tg, ptk, ptg);
        #1;
        chk("mispredict", {31'd0, mispredict}, {31'd0, emis});
        chk("redirect_pc", redirect_pc, ered);
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h40;
        set_upd(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        upd_valid = 1'b0;

        @(negedge clk);
        look(32'h40, 1'b0, 32'h44);
        counts(32'd0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Train taken three times: counter 10 -> 11 -> 11.
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
        look(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100);
        upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100);
        look(32'h40, 1'b1, 32'h100);
        counts(32'd3, 32'd1);

        // Two not-taken: 11 -> 10 (still taken) -> 01.
        upd(32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44);
        look(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44);
        look(32'h40, 1'b0, 32'h44);
        counts(32'd5, 32'd3);

        // Floor saturation: 01 -> 00 -> 00 -> 01 -> 10.
        upd(32'h40, 1'b0, 32'h100, 1'b0, 32'h44, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h100, 1'b0, 32'h44, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
        look(32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
        look(32'h40, 1'b1, 32'h100);
        counts(32'd9, 32'd5);

        // Same direction, wrong target.
        upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 32'h200);
        look(32'h40, 1'b1, 32'h200);
        counts(32'd10, 32'd6);

        // Alias update on 0x80 with a same-cycle lookup of 0x40.
        if_pc = 32'h40;
        set_upd(32'h80, 1'b0, 32'h900, 1'b0, 32'h84);
        #1;
        chk("same_cycle_taken", {31'd0, pred_taken}, 32'd1);
        chk("same_cycle_target", pred_target, 32'h200);
        chk("alias_mispredict", {31'd0, mispredict}, 32'd0);
        chk("alias_redirect", redirect_pc, 32'h84);
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        look(32'h40, 1'b0, 32'h44);
        look(32'h80, 1'b0, 32'h84);
        counts(32'd11, 32'd6);

        // Reallocate back to 0x40 as taken: counter 10, target 0x500.
        upd(32'h40, 1'b1, 32'h500, 1'b0, 32'h44, 1'b1, 32'h500);
        look(32'h40, 1'b1, 32'h500);
        look(32'h80, 1'b0, 32'h84);

        // PC wrap-around at the top of the address space.
        upd(32'hFFFF_FFFC, 1'b0, 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0);
        look(32'hFFFF_FFFC, 1'b0, 32'h0);
        counts(32'd13, 32'd7);

        // upd_valid low: outcome would flip the entry, but nothing may change.
        set_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h500);
        upd_valid = 1'b0;
        #1;
        chk("idle_mispredict", {31'd0, mispredict}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        look(32'h40, 1'b1, 32'h500);
        counts(32'd13, 32'd7);

        // Asynchronous reset in the middle of an update cycle.
        set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h44);
        counts(32'd0, 32'd0);
        @(posedge clk);
        #1;
        counts(32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release performs the pending update.
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        look(32'h40, 1'b1, 32'h100);
        counts(32'd1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
